// File: rtl/ternary_neuron_acc_pkg.sv
// Shared definitions for the ternary-neuron back end.
// Contents: activation encodings, FSM state enum, and the saturating accumulate helper.
// Users: ternary_neuron_acc, tnn_ternary_act and the parallel neuron variant.
package tnn_pkg;

  localparam logic [1:0] ACT_POS  = 2'b01;
  localparam logic [1:0] ACT_ZERO = 2'b00;
  localparam logic [1:0] ACT_NEG  = 2'b11;

  // Fixed working width for sat_add. It must exceed every accumulator
  // width in use by at least one bit, so acc + d can never wrap before
  // the clamp.
  localparam int SAT_MAX_W = 32;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Signed add, clamped to the range of an acc_w-bit two's complement value.
  function automatic logic signed [SAT_MAX_W-1:0] sat_add(
    input logic signed [SAT_MAX_W-1:0] acc,
    input logic signed [SAT_MAX_W-1:0] d,
    input int                          acc_w
  );
    logic signed [SAT_MAX_W-1:0] total;
    logic signed [SAT_MAX_W-1:0] max_v;
    logic signed [SAT_MAX_W-1:0] min_v;
    total = acc + d;
    max_v = (SAT_MAX_W'(1) << (acc_w - 1)) - 1;
    min_v = ~max_v;  // -(2^(acc_w-1))
    if (total > max_v)      sat_add = max_v;
    else if (total < min_v) sat_add = min_v;
    else                    sat_add = total;
  endfunction

endpackage

// File: rtl/ternary_neuron_acc_if.sv
// Slice-input / activation-output bundle for ternary_neuron_acc.
// master: upstream popcount stage plus downstream consumer (drives slices, thresholds, flush, out_ready).
// slave:  the neuron accumulator (drives in_ready, chunk_idx, out_valid, out_act, out_sum).
interface ternary_neuron_acc_if #(
  parameter int PC_W  = 5,
  parameter int ACC_W = 9,
  parameter int IDX_W = 2
);
  logic                    flush;
  logic [PC_W-1:0]         pc_pos;
  logic [PC_W-1:0]         pc_neg;
  logic                    in_valid;
  logic                    in_ready;
  logic [IDX_W-1:0]        chunk_idx;
  logic signed [ACC_W-1:0] thr_hi;
  logic signed [ACC_W-1:0] thr_lo;
  logic                    out_valid;
  logic                    out_ready;
  logic [1:0]              out_act;
  logic signed [ACC_W-1:0] out_sum;

  modport master (
    output flush, pc_pos, pc_neg, in_valid, thr_hi, thr_lo, out_ready,
    input  in_ready, chunk_idx, out_valid, out_act, out_sum
  );

  modport slave (
    input  flush, pc_pos, pc_neg, in_valid, thr_hi, thr_lo, out_ready,
    output in_ready, chunk_idx, out_valid, out_act, out_sum
  );
endinterface

// File: rtl/ternary_neuron_acc_act.sv
// Ternary threshold: sum > thr_hi gives +1, sum < thr_lo gives -1, otherwise 0 (signed compares).
// Latency: purely combinational.
// Ports: sum, thr_hi, thr_lo (signed ACC_W) in; act (2-bit ternary code) out.
module tnn_ternary_act
  import tnn_pkg::*;
#(
  parameter int ACC_W = 9
) (
  input  logic signed [ACC_W-1:0] sum,
  input  logic signed [ACC_W-1:0] thr_hi,
  input  logic signed [ACC_W-1:0] thr_lo,
  output logic [1:0]              act
);

  always_comb begin
    act = ACT_ZERO;
    if (sum > thr_hi)      act = ACT_POS;
    else if (sum < thr_lo) act = ACT_NEG;
  end

endmodule

// File: rtl/ternary_neuron_acc.sv
// Accumulates saturated (pc_pos - pc_neg) over N_CHUNKS slices, then emits one ternary activation.
// Latency: result valid the cycle after the last slice; one bubble after the output handshake.
// Ports: clk, rst (async active-high); bus (slave): slice valid/ready in, activation valid/ready out, flush.
module ternary_neuron_acc
  import tnn_pkg::*;
#(
  parameter int PC_W     = 5,
  parameter int N_CHUNKS = 4,
  parameter int ACC_W    = 9,
  parameter int IDX_W    = 2
) (
  input logic                 clk,
  input logic                 rst,
  ternary_neuron_acc_if.slave bus
);

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [PC_W:0]    delta;
  logic [IDX_W-1:0]        idx;
  logic [1:0]              act_q;
  logic [1:0]              act_nxt;
  logic signed [ACC_W-1:0] sum_q;
  logic                    xfer;
  logic                    last;

  // Both popcounts are zero-extended so the full 0..2^PC_W-1 range survives.
  assign delta    = signed'({1'b0, bus.pc_pos}) - signed'({1'b0, bus.pc_neg});
  assign acc_next = ACC_W'(sat_add(SAT_MAX_W'(acc), SAT_MAX_W'(delta), ACC_W));

  // Acceptance is derived from state, not from in_ready, to keep the
  // handshake free of combinational feedback through the interface.
  assign xfer = bus.in_valid && (state == ACCUM);
  assign last = (idx == IDX_W'(N_CHUNKS - 1));

  tnn_ternary_act #(.ACC_W(ACC_W)) u_act (
    .sum    (acc_next),
    .thr_hi (bus.thr_hi),
    .thr_lo (bus.thr_lo),
    .act    (act_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      ACCUM: begin
        bus.in_ready = 1'b1;
        if (xfer && last) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
    // Abort wins over any transfer or pending result this cycle.
    if (bus.flush) state_nxt = ACCUM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      idx   <= '0;
      act_q <= ACT_ZERO;
      sum_q <= '0;
    end else if (bus.flush) begin
      acc <= '0;
      idx <= '0;
    end else if (xfer) begin
      if (last) begin
        sum_q <= acc_next;
        act_q <= act_nxt;
        acc   <= '0;
        idx   <= '0;
      end else begin
        acc <= acc_next;
        idx <= idx + IDX_W'(1);
      end
    end
  end

  assign bus.chunk_idx = idx;
  assign bus.out_act   = act_q;
  assign bus.out_sum   = sum_q;

endmodule

// File: tb/tb_ternary_neuron_acc.sv
module tb_ternary_neuron_acc;

  localparam int PC_W  = 5;
  localparam int NCH   = 4;
  localparam int ACC_W = 9;
  localparam int IDX_W = 2;
  localparam int ACC_B = 7;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  ternary_neuron_acc_if #(.PC_W(PC_W), .ACC_W(ACC_W), .IDX_W(IDX_W)) a ();
  ternary_neuron_acc_if #(.PC_W(PC_W), .ACC_W(ACC_B), .IDX_W(IDX_W)) b ();

  ternary_neuron_acc #(.PC_W(PC_W), .N_CHUNKS(NCH), .ACC_W(ACC_W), .IDX_W(IDX_W))
    dut (.clk(clk), .rst(rst), .bus(a));
  ternary_neuron_acc #(.PC_W(PC_W), .N_CHUNKS(NCH), .ACC_W(ACC_B), .IDX_W(IDX_W))
    dut_b (.clk(clk), .rst(rst), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      assert (a.thr_lo <= a.thr_hi) else $error("thr_lo above thr_hi on bus a");
      assert (b.thr_lo <= b.thr_hi) else $error("thr_lo above thr_hi on bus b");
    end
  end

  typedef logic [NCH-1:0][PC_W-1:0] slices_t;

  typedef struct {
    slices_t    p;
    slices_t    n;
    int         hi;
    int         lo;
    int         sum;
    logic [1:0] act;
  } vec_t;

  vec_t tbl[8];

  function automatic vec_t mk(input int p0, p1, p2, p3, n0, n1, n2, n3,
                              input int hi, lo, sum, input logic [1:0] act);
    vec_t v;
    v.p[0] = PC_W'(p0); v.p[1] = PC_W'(p1); v.p[2] = PC_W'(p2); v.p[3] = PC_W'(p3);
    v.n[0] = PC_W'(n0); v.n[1] = PC_W'(n1); v.n[2] = PC_W'(n2); v.n[3] = PC_W'(n3);
    v.hi = hi; v.lo = lo; v.sum = sum; v.act = act;
    return v;
  endfunction

  // Reference: running signed sum clamped after every slice to the w-bit range.
  function automatic int model_sum(input slices_t p, input slices_t n, input int w);
    int s;
    int mx;
    int mn;
    s  = 0;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    for (int k = 0; k < NCH; k++) begin
      s = s + int'(p[k]) - int'(n[k]);
      if (s > mx) s = mx;
      if (s < mn) s = mn;
    end
    return s;
  endfunction

  function automatic logic [1:0] model_act(input int s, input int hi, input int lo);
    if (s > hi) return 2'b01;
    if (s < lo) return 2'b11;
    return 2'b00;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds four slices on bus a (optionally with idle gaps) and checks the result.
  task automatic run_eval(input slices_t p, input slices_t n, input bit gaps,
                          input int exp_sum, input logic [1:0] exp_act, input string nm);
    for (int k = 0; k < NCH; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          a.in_valid = 1'b0;
          tick();
        end
      end
      chk({nm, "_idx"}, int'(a.chunk_idx), k);
      a.pc_pos   = p[k];
      a.pc_neg   = n[k];
      a.in_valid = 1'b1;
      tick();
      a.in_valid = 1'b0;
      if (k < NCH - 1) chk({nm, "_early_valid"}, int'(a.out_valid), 0);
    end
    chk({nm, "_valid"}, int'(a.out_valid), 1);
    chk({nm, "_in_ready"}, int'(a.in_ready), 0);
    chk({nm, "_sum"}, int'(a.out_sum), exp_sum);
    chk({nm, "_act"}, int'(a.out_act), int'(exp_act));
  endtask

  task automatic handshake(input string nm);
    int w;
    w = 0;
    a.out_ready = 1'b1;
    while (a.out_valid !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    if (w == 20) chk({nm, "_hs_timeout"}, int'(a.out_valid), 1);
    tick();
    a.out_ready = 1'b0;
    chk({nm, "_after_hs_valid"}, int'(a.out_valid), 0);
    chk({nm, "_after_hs_ready"}, int'(a.in_ready), 1);
  endtask

  task automatic run_eval_b(input slices_t p, input slices_t n, input int hi, input int lo,
                            input string nm);
    int s;
    s = model_sum(p, n, ACC_B);
    b.thr_hi = ACC_B'(hi);
    b.thr_lo = ACC_B'(lo);
    for (int k = 0; k < NCH; k++) begin
      b.pc_pos   = p[k];
      b.pc_neg   = n[k];
      b.in_valid = 1'b1;
      tick();
    end
    b.in_valid = 1'b0;
    chk({nm, "_valid"}, int'(b.out_valid), 1);
    chk({nm, "_sum"}, int'(b.out_sum), s);
    chk({nm, "_act"}, int'(b.out_act), int'(model_act(s, hi, lo)));
    b.out_ready = 1'b1;
    tick();
    b.out_ready = 1'b0;
    chk({nm, "_after_hs"}, int'(b.out_valid), 0);
  endtask

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    slices_t rp;
    slices_t rn;
    int      rh;
    int      rl;
    int      t0;
    int      t1;
    int      es;

    tbl[0] = mk(20, 3, 0, 7,   5, 3, 2, 0,      10, -10,   20, 2'b01);
    tbl[1] = mk(0, 0, 0, 0,    31, 31, 31, 31,  10, -10, -124, 2'b11);
    tbl[2] = mk(10, 0, 0, 0,   0, 0, 0, 0,      10, -10,   10, 2'b00);
    tbl[3] = mk(0, 0, 0, 0,    10, 0, 0, 0,     10, -10,  -10, 2'b00);
    tbl[4] = mk(31, 31, 31, 31, 0, 0, 0, 0,     10, -10,  124, 2'b01);
    tbl[5] = mk(6, 5, 0, 0,    0, 0, 0, 0,      10, -10,   11, 2'b01);
    tbl[6] = mk(0, 0, 0, 0,    4, 7, 0, 0,      10, -10,  -11, 2'b11);
    tbl[7] = mk(5, 5, 0, 0,    5, 5, 0, 0,       0,   0,    0, 2'b00);

    {a.flush, a.in_valid, a.out_ready, a.pc_pos, a.pc_neg} = '0;
    {b.flush, b.in_valid, b.out_ready, b.pc_pos, b.pc_neg} = '0;
    a.thr_hi = 9'sd10;  a.thr_lo = -9'sd10;
    b.thr_hi = 7'sd10;  b.thr_lo = -7'sd10;

    rst = 1'b1;
    #12;
    chk("rst_in_ready", int'(a.in_ready), 1);
    chk("rst_out_valid", int'(a.out_valid), 0);
    chk("rst_out_act", int'(a.out_act), 0);
    chk("rst_out_sum", int'(a.out_sum), 0);
    chk("rst_chunk_idx", int'(a.chunk_idx), 0);
    rst = 1'b0;
    tick();

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      a.thr_hi = ACC_W'(tbl[i].hi);
      a.thr_lo = ACC_W'(tbl[i].lo);
      run_eval(tbl[i].p, tbl[i].n, 1'b0, tbl[i].sum, tbl[i].act, $sformatf("tbl%0d", i));
      handshake($sformatf("tbl%0d", i));
    end

    // Backpressure: result held for 5 cycles while in_valid is ignored
    a.thr_hi = 9'sd10; a.thr_lo = -9'sd10;
    run_eval(tbl[0].p, tbl[0].n, 1'b0, 20, 2'b01, "bp");
    for (int c = 0; c < 5; c++) begin
      a.in_valid = 1'b1;
      a.pc_pos   = PC_W'($urandom_range(0, 31));
      a.pc_neg   = PC_W'($urandom_range(0, 31));
      tick();
      chk("bp_hold_valid", int'(a.out_valid), 1);
      chk("bp_hold_ready", int'(a.in_ready), 0);
      chk("bp_hold_sum", int'(a.out_sum), 20);
      chk("bp_hold_act", int'(a.out_act), 1);
      chk("bp_hold_idx", int'(a.chunk_idx), 0);
    end
    a.in_valid = 1'b0;
    handshake("bp");
    run_eval(tbl[2].p, tbl[2].n, 1'b0, 10, 2'b00, "bp_next");
    handshake("bp_next");

    // flush coincident with the third slice transfer
    for (int k = 0; k < 2; k++) begin
      a.pc_pos = 5'd9; a.pc_neg = 5'd0; a.in_valid = 1'b1;
      tick();
    end
    a.flush = 1'b1;
    tick();
    a.flush = 1'b0;
    a.in_valid = 1'b0;
    chk("flush_idx", int'(a.chunk_idx), 0);
    chk("flush_valid", int'(a.out_valid), 0);
    run_eval(tbl[5].p, tbl[5].n, 1'b0, 11, 2'b01, "post_flush");
    handshake("post_flush");

    // flush while holding a result
    run_eval(tbl[0].p, tbl[0].n, 1'b0, 20, 2'b01, "flush_done");
    a.flush = 1'b1;
    tick();
    a.flush = 1'b0;
    chk("flush_done_valid", int'(a.out_valid), 0);
    chk("flush_done_ready", int'(a.in_ready), 1);

    // Asynchronous reset mid-evaluation, away from any clock edge
    for (int k = 0; k < 2; k++) begin
      a.pc_pos = 5'd12; a.pc_neg = 5'd1; a.in_valid = 1'b1;
      tick();
    end
    a.in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("arst_idx", int'(a.chunk_idx), 0);
    chk("arst_sum", int'(a.out_sum), 0);
    chk("arst_ready", int'(a.in_ready), 1);
    chk("arst_valid", int'(a.out_valid), 0);
    #2 rst = 1'b0;
    run_eval(tbl[6].p, tbl[6].n, 1'b0, model_sum(tbl[6].p, tbl[6].n, ACC_W), 2'b11, "post_rst");
    handshake("post_rst");

    // Narrow accumulator: saturation applied after each slice
    run_eval_b(tbl[1].p, tbl[1].n, 10, -10, "b_negsat");
    run_eval_b(tbl[4].p, tbl[4].n, 10, -10, "b_possat");
    rp = '0; rn = '0;
    rn[0] = 5'd31; rn[1] = 5'd31; rn[2] = 5'd31; rp[3] = 5'd31;
    run_eval_b(rp, rn, 10, -10, "b_sat_recover");

    // Randomized evaluations against the reference model
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < NCH; k++) begin
        rp[k] = PC_W'($urandom_range(0, 31));
        rn[k] = PC_W'($urandom_range(0, 31));
      end
      t0 = int'($urandom_range(0, 80)) - 40;
      t1 = int'($urandom_range(0, 80)) - 40;
      rh = (t0 > t1) ? t0 : t1;
      rl = (t0 > t1) ? t1 : t0;
      a.thr_hi = ACC_W'(rh);
      a.thr_lo = ACC_W'(rl);
      es = model_sum(rp, rn, ACC_W);
      run_eval(rp, rn, 1'b1, es, model_act(es, rh, rl), $sformatf("rnd%0d", r));
      repeat ($urandom_range(0, 3)) begin
        tick();
        chk("rnd_wait_valid", int'(a.out_valid), 1);
      end
      handshake($sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ternary_neuron_acc.md
Name: ternary_neuron_acc

Overview:
- Ternary-neuron back end for the printed-NN datapath. It sits directly downstream of the 27-input approximate popcount stage.
- Each neuron fan-in is split into N_CHUNKS slices of 27 inputs. Two popcount instances per slice, one for the +1-weight lanes and one for the -1-weight lanes, feed this block one slice per handshake.
- The block accumulates (pos - neg) over all slices, applies two thresholds and emits one ternary activation per neuron, with valid/ready on both sides.

Parameters:
- PC_W, 5, width of each popcount input (unsigned).
- N_CHUNKS, 4, slices per neuron evaluation. Must be at least 1.
- ACC_W, 9, signed accumulator width, two's complement.
- IDX_W, 2, chunk index width, equal to ceil(log2(N_CHUNKS)), minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of the evaluation in progress.
- pc_pos  in  PC_W  popcount of the +1-weight lanes for the current slice.
- pc_neg  in  PC_W  popcount of the -1-weight lanes for the current slice.
- in_valid  in  1  pc_pos and pc_neg are valid.
- in_ready  out  1  block accepts a slice this cycle.
- chunk_idx  out  IDX_W  index of the slice expected next; upstream uses it to select the input/weight slice.
- thr_hi  in  ACC_W  signed upper threshold; held stable during an evaluation.
- thr_lo  in  ACC_W  signed lower threshold; thr_lo <= thr_hi is required.
- out_valid  out  1  activation available.
- out_ready  in  1  downstream accepts the activation.
- out_act  out  2  ternary activation: 2'b01 = +1, 2'b00 = 0, 2'b11 = -1. 2'b10 is never driven.
- out_sum  out  ACC_W  final saturated signed sum, for debug/verification.

Behaviour:
- Reset is asynchronous, active-high (rst). Reset values:
  - state = ACCUM
  - acc = 0, chunk_idx = 0
  - in_ready = 1, out_valid = 0
  - out_act = 2'b00, out_sum = 0
- States:
  - ACCUM: in_ready = 1, out_valid = 0.
  - DONE: in_ready = 0, out_valid = 1, out_act and out_sum held stable.
- Input transfer occurs when in_valid && in_ready.
- Per-chunk delta:
  - d = zero-extended pc_pos - zero-extended pc_neg, range [-(2^PC_W - 1), 2^PC_W - 1].
  - The full 5-bit range is honoured because the approximate popcount can exceed 27.
- Accumulation on each transfer:
  - acc_next = sat(acc + d), saturating to [-2^(ACC_W-1), 2^(ACC_W-1) - 1].
  - Intermediate sum is computed at ACC_W + 1 bits.
- Not the last chunk (chunk_idx != N_CHUNKS - 1): acc <= acc_next, chunk_idx increments, state stays ACCUM.
- Last chunk (chunk_idx == N_CHUNKS - 1), on transfer:
  - out_sum <= acc_next.
  - out_act <= +1 if acc_next > thr_hi; -1 if acc_next < thr_lo; else 0. Comparisons are signed.
  - acc <= 0, chunk_idx <= 0, state goes to DONE.
  - Latency: last slice accepted at edge t, out_valid high after edge t, visible in cycle t+1.
- DONE:
  - Leaves on out_valid && out_ready and returns to ACCUM at the next edge.
  - A new slice can be accepted no earlier than the cycle after the output handshake (one bubble).
  - Throughput is one neuron per N_CHUNKS + 1 cycles with no backpressure.
  - out_act and out_sum keep their last values after the handshake; they are only meaningful while out_valid = 1.
- flush (synchronous) has priority over any input transfer in the same cycle:
  - acc <= 0, chunk_idx <= 0, state <= ACCUM.
  - Any pending output is dropped: out_valid <= 0.
- An output handshake coinciding with flush is counted as consumed; this is harmless.
- N_CHUNKS = 1: every accepted slice goes directly to DONE.
- rst asserted mid-evaluation clears everything immediately, with no partial output.
- Threshold equality: acc_next == thr_hi gives 0; acc_next == thr_lo gives 0 unless thr_lo > thr_hi, which is illegal. A bench assertion flags thr_lo > thr_hi.

Decomposition:
- Shared package tnn_pkg holds:
  - localparams for the activation encodings ACT_POS / ACT_ZERO / ACT_NEG
  - the state enum {ACCUM, DONE}
  - a function sat_add(acc, d) parameterised by ACC_W via a fixed maximum width
- One sub-module is natural: tnn_ternary_act, a purely combinational block (sum, thr_hi, thr_lo to 2-bit activation). It is reused by the parallel neuron variant.

Test Plan:
- N_CHUNKS=4, thr_hi=10, thr_lo=-10; slices (pos,neg) = (20,5), (3,3), (0,2), (7,0) -> sum 20, out_act=2'b01, out_valid in the cycle after the 4th transfer; chunk_idx goes 0,1,2,3,0.
- Slices (0,31) x4 -> sum -124, out_act=2'b11. Same with ACC_W=7 -> saturates at -64, out_act=2'b11, out_sum=-64.
- Sum exactly 10 with thr_hi=10 -> out_act=2'b00. Sum -10 with thr_lo=-10 -> 2'b00.
- out_ready held low 5 cycles in DONE -> out_valid stays 1, out_act/out_sum stable, in_ready=0, in_valid ignored; release -> handshake, in_ready=1 next cycle.
- flush asserted together with the 3rd slice transfer -> slice discarded, chunk_idx=0, acc=0; next 4 slices produce a clean result. flush in DONE -> out_valid drops next cycle.
- rst pulsed asynchronously mid-cycle after 2 slices -> outputs go to reset values immediately; the following evaluation matches a reference model.
